// File: rtl/sumador_nbits_pipe.sv
// Pipelined two's-complement adder/subtractor with a valid/ready handshake,
// signed/unsigned overflow detection, optional saturation and an overflow event counter.
module sumador_nbits_pipe #(
    parameter int WIDTH    = 16,
    parameter int STAGES   = 2,
    parameter int SIGNED   = 1,
    parameter int SATURATE = 0,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             overflow,
    input  logic             ovf_clr,
    output logic [CNT_W-1:0] ovf_count
);

    logic [WIDTH-1:0]  b_eff;
    logic [WIDTH:0]    sum_ext;
    logic [WIDTH-1:0]  sum_raw;
    logic [WIDTH-1:0]  sum_fin;
    logic              sum_ovf;

    logic [STAGES-1:0] stg_vld;
    logic [STAGES-1:0] stg_ovf;
    logic [WIDTH-1:0]  stg_res [STAGES];
    logic [STAGES-1:0] load;
    logic              ld_chain;
    logic              ovf_xfer;

    // Subtraction reuses the adder as a + ~b + 1; the extra bit is the carry-out.
    always_comb begin
        b_eff   = op ? ~b : b;
        sum_ext = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, op};
        sum_raw = sum_ext[WIDTH-1:0];
        if (SIGNED != 0) begin
            sum_ovf = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum_raw[WIDTH-1] != a[WIDTH-1]);
        end else begin
            sum_ovf = op ? ~sum_ext[WIDTH] : sum_ext[WIDTH];
        end
        sum_fin = sum_raw;
        if ((SATURATE != 0) && sum_ovf) begin
            if (SIGNED != 0) begin
                sum_fin = a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
            end else begin
                sum_fin = op ? {WIDTH{1'b0}} : {WIDTH{1'b1}};
            end
        end
    end

    // A stage may load when it is empty or its content moves on, so bubbles collapse under stall.
    always_comb begin
        load     = '0;
        ld_chain = !stg_vld[STAGES-1] || out_ready;
        load[STAGES-1] = ld_chain;
        for (int k = STAGES - 2; k >= 0; k--) begin
            ld_chain = !stg_vld[k] || ld_chain;
            load[k]  = ld_chain;
        end
    end

    assign in_ready  = load[0] && !rst;
    assign out_valid = stg_vld[STAGES-1];
    assign result    = stg_res[STAGES-1];
    assign overflow  = stg_ovf[STAGES-1];
    assign ovf_xfer  = stg_vld[STAGES-1] && out_ready && stg_ovf[STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stg_vld <= '0;
            stg_ovf <= '0;
            for (int k = 0; k < STAGES; k++) begin
                stg_res[k] <= '0;
            end
        end else begin
            if (load[0]) begin
                stg_vld[0] <= in_valid;
                stg_res[0] <= sum_fin;
                stg_ovf[0] <= sum_ovf;
            end
            for (int k = 1; k < STAGES; k++) begin
                if (load[k]) begin
                    stg_vld[k] <= stg_vld[k-1];
                    stg_res[k] <= stg_res[k-1];
                    stg_ovf[k] <= stg_ovf[k-1];
                end
            end
        end
    end

    // The counter sticks at its maximum; a clear takes priority over a same-cycle event.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_count <= '0;
        end else if (ovf_clr) begin
            ovf_count <= '0;
        end else if (ovf_xfer && (ovf_count != {CNT_W{1'b1}})) begin
            ovf_count <= ovf_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_sumador_nbits_pipe.sv
// Directed bench for sumador_nbits_pipe: four arithmetic variants share one stimulus stream
// (signed wrap, unsigned wrap, signed saturate, unsigned saturate).
module tb_sumador_nbits_pipe;

    typedef struct {
        logic [15:0]      a;
        logic [15:0]      b;
        logic             op;
        logic [3:0][15:0] r;
        logic [3:0]       o;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [15:0] a;
    logic [15:0] b;
    logic        op;
    logic        out_ready;
    logic        ovf_clr;

    logic [3:0]  ir;
    logic [3:0]  ov;
    logic [3:0]  of;
    logic [15:0] res [4];
    logic [7:0]  cnt [4];

    vec_t        vec [10];
    logic [15:0] bp_exp [6];
    int          nChecks;
    int          nFails;

    sumador_nbits_pipe #(.WIDTH(16), .STAGES(2), .SIGNED(1), .SATURATE(0), .CNT_W(8)) d0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]), .a(a), .b(b), .op(op),
        .out_valid(ov[0]), .out_ready(out_ready), .result(res[0]), .overflow(of[0]),
        .ovf_clr(ovf_clr), .ovf_count(cnt[0]));

    sumador_nbits_pipe #(.WIDTH(16), .STAGES(2), .SIGNED(0), .SATURATE(0), .CNT_W(8)) d1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]), .a(a), .b(b), .op(op),
        .out_valid(ov[1]), .out_ready(out_ready), .result(res[1]), .overflow(of[1]),
        .ovf_clr(ovf_clr), .ovf_count(cnt[1]));

    sumador_nbits_pipe #(.WIDTH(16), .STAGES(2), .SIGNED(1), .SATURATE(1), .CNT_W(8)) d2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[2]), .a(a), .b(b), .op(op),
        .out_valid(ov[2]), .out_ready(out_ready), .result(res[2]), .overflow(of[2]),
        .ovf_clr(ovf_clr), .ovf_count(cnt[2]));

    sumador_nbits_pipe #(.WIDTH(16), .STAGES(2), .SIGNED(0), .SATURATE(1), .CNT_W(8)) d3 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[3]), .a(a), .b(b), .op(op),
        .out_valid(ov[3]), .out_ready(out_ready), .result(res[3]), .overflow(of[3]),
        .ovf_clr(ovf_clr), .ovf_count(cnt[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setVec(input int i, input logic [15:0] va, input logic [15:0] vb, input logic vop,
                          input logic [15:0] r0, input logic o0, input logic [15:0] r1, input logic o1,
                          input logic [15:0] r2, input logic o2, input logic [15:0] r3, input logic o3);
        vec[i].a  = va;
        vec[i].b  = vb;
        vec[i].op = vop;
        vec[i].r  = {r3, r2, r1, r0};
        vec[i].o  = {o3, o2, o1, o0};
    endtask

    // One operation with the consumer always ready: accept, check latency, check all variants.
    task automatic applyStimulus(input int i);
        out_ready = 1'b1;
        a         = vec[i].a;
        b         = vec[i].b;
        op        = vec[i].op;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        checkOutput($sformatf("vec%0d_valid_early", i), {31'd0, ov[0]}, 32'd0);
        tick();
        checkOutput($sformatf("vec%0d_valid", i), {31'd0, ov[0]}, 32'd1);
        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("vec%0d_res_d%0d", i, k), {16'd0, res[k]}, {16'd0, vec[i].r[k]});
            checkOutput($sformatf("vec%0d_ovf_d%0d", i, k), {31'd0, of[k]}, {31'd0, vec[i].o[k]});
        end
        tick();
    endtask

    initial begin
        int sent;
        int got;
        int accStalled;
        int accepted;
        logic sIr;
        logic sOv;
        logic [15:0] sRes;

        nChecks   = 0;
        nFails    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        ovf_clr   = 1'b0;
        a         = '0;
        b         = '0;
        op        = 1'b0;

        //        i  a        b        op    sign-wrap      unsign-wrap    sign-sat       unsign-sat
        setVec(0, 16'h2222, 16'h4444, 1'b0, 16'h6666, 1'b0, 16'h6666, 1'b0, 16'h6666, 1'b0, 16'h6666, 1'b0);
        setVec(1, 16'h2222, 16'h4444, 1'b1, 16'hDDDE, 1'b0, 16'hDDDE, 1'b1, 16'hDDDE, 1'b0, 16'h0000, 1'b1);
        setVec(2, 16'hFFFF, 16'hFFFF, 1'b0, 16'hFFFE, 1'b0, 16'hFFFE, 1'b1, 16'hFFFE, 1'b0, 16'hFFFF, 1'b1);
        setVec(3, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b1, 16'h8000, 1'b0, 16'h7FFF, 1'b1, 16'h8000, 1'b0);
        setVec(4, 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 16'h7FFF, 1'b0, 16'h8000, 1'b1, 16'h7FFF, 1'b0);
        setVec(5, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b1, 16'h8000, 1'b1, 16'hFFFF, 1'b1);
        setVec(6, 16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b0, 16'hFFFF, 1'b1, 16'hFFFF, 1'b0, 16'h0000, 1'b1);
        setVec(7, 16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
        setVec(8, 16'h1234, 16'h0000, 1'b0, 16'h1234, 1'b0, 16'h1234, 1'b0, 16'h1234, 1'b0, 16'h1234, 1'b0);
        setVec(9, 16'h7FFF, 16'hFFFF, 1'b1, 16'h8000, 1'b1, 16'h8000, 1'b1, 16'h7FFF, 1'b1, 16'h0000, 1'b1);

        // Reset state
        #2;
        checkOutput("rst_out_valid", {31'd0, ov[0]}, 32'd0);
        checkOutput("rst_result", {16'd0, res[0]}, 32'd0);
        checkOutput("rst_overflow", {31'd0, of[0]}, 32'd0);
        checkOutput("rst_ovf_count", {24'd0, cnt[0]}, 32'd0);
        checkOutput("rst_in_ready", {31'd0, ir[0]}, 32'd0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        checkOutput("in_ready_after_rst", {31'd0, ir[0]}, 32'd1);

        // Arithmetic table
        for (int i = 0; i < 10; i++) begin
            applyStimulus(i);
        end
        checkOutput("table_cnt_d0", {24'd0, cnt[0]}, 32'd4);
        checkOutput("table_cnt_d1", {24'd0, cnt[1]}, 32'd5);
        checkOutput("table_cnt_d2", {24'd0, cnt[2]}, 32'd4);
        checkOutput("table_cnt_d3", {24'd0, cnt[3]}, 32'd5);

        // Backpressure: six ops, consumer stalled for the first five cycles
        for (int i = 0; i < 6; i++) begin
            bp_exp[i] = (i % 2 == 1) ? 16'(256 * (i + 1) - (i + 3)) : 16'(256 * (i + 1) + (i + 3));
        end
        sent       = 0;
        got        = 0;
        accStalled = 0;
        for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
            out_ready = (cyc >= 5);
            in_valid  = (sent < 6);
            a         = 16'(256 * (sent + 1));
            b         = 16'(sent + 3);
            op        = sent[0];
            #1;
            sIr  = ir[0];
            sOv  = ov[0];
            sRes = res[0];
            if (cyc == 2) checkOutput("bp_in_ready_low", {31'd0, sIr}, 32'd0);
            if (sOv) begin
                if (got < 6) checkOutput($sformatf("bp_result%0d", got), {16'd0, sRes}, {16'd0, bp_exp[got]});
                else checkOutput("bp_extra_output", {31'd0, sOv}, 32'd0);
            end
            @(posedge clk);
            if (in_valid && sIr) begin
                sent++;
                if (!out_ready) accStalled++;
            end
            if (sOv && out_ready) got++;
            #1;
        end
        in_valid = 1'b0;
        checkOutput("bp_accepts_stalled", accStalled, 32'd2);
        checkOutput("bp_sent", sent, 32'd6);
        checkOutput("bp_delivered", got, 32'd6);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("bp_no_duplicate", {31'd0, ov[0]}, 32'd0);
        end

        // Counter saturation with 300 overflowing ops
        out_ready = 1'b1;
        a         = 16'h7FFF;
        b         = 16'h0001;
        op        = 1'b0;
        accepted  = 0;
        for (int cyc = 0; cyc < 400 && accepted < 300; cyc++) begin
            in_valid = 1'b1;
            #1;
            sIr = ir[0];
            @(posedge clk);
            if (sIr) accepted++;
            #1;
        end
        in_valid = 1'b0;
        checkOutput("sat_accepted", accepted, 32'd300);
        tick();
        tick();
        tick();
        checkOutput("sat_cnt_d0", {24'd0, cnt[0]}, 32'd255);
        checkOutput("sat_cnt_d1", {24'd0, cnt[1]}, 32'd5);
        checkOutput("sat_cnt_d2", {24'd0, cnt[2]}, 32'd255);

        // Clear coinciding with an overflow delivery
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        checkOutput("clr_pending_ovf", {31'd0, of[0] & ov[0]}, 32'd1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        checkOutput("clr_wins", {24'd0, cnt[0]}, 32'd0);
        tick();
        checkOutput("clr_holds", {24'd0, cnt[0]}, 32'd0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        checkOutput("cnt_after_clr", {24'd0, cnt[0]}, 32'd1);

        // Reset with two ops in flight
        out_ready = 1'b0;
        in_valid  = 1'b1;
        tick();
        tick();
        in_valid = 1'b0;
        checkOutput("inflight_valid", {31'd0, ov[0]}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midrst_out_valid", {31'd0, ov[0]}, 32'd0);
        checkOutput("midrst_ovf_count", {24'd0, cnt[0]}, 32'd0);
        checkOutput("midrst_in_ready", {31'd0, ir[0]}, 32'd0);
        checkOutput("midrst_result", {16'd0, res[0]}, 32'd0);
        tick();
        tick();
        rst       = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput("no_stale_result", {31'd0, ov[0]}, 32'd0);
        end
        applyStimulus(0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
